// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and restoring divide with HI/LO result registers.
// Optional MULTDIV_EARLY_TERM_EN: multiplies exit as soon as the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CNT_W-1:0] iter_count
);

`ifdef MULTDIV_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX} state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q, dvsr_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 quot_neg_q, rem_neg_q, busy_q, done_q, dbz_q;

    logic                 is_div, is_signed, dz, mult_rest_zero;
    logic [WIDTH-1:0]     a_mag, b_mag, rem_mask, quot_fix, rem_fix;
    logic [WIDTH:0]       mult_sum, trial;
    logic [2*WIDTH-1:0]   mult_acc, div_acc, prod_fix;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        dz        = is_div && (b_q == '0);
        a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

        // Shift-add: multiplier sits in the low half of acc and is consumed from bit 0.
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvsr_q : '0)};
        mult_acc  = {mult_sum, acc_q[WIDTH-1:1]};

        // Restoring step on the {remainder, quotient} pair.
        trial     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};
        div_acc   = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        rem_mask       = (WIDTH'(1) << cnt_q) - WIDTH'(1);
        mult_rest_zero = (acc_q[WIDTH-1:0] & rem_mask) == '0;

        prod_fix  = quot_neg_q ? -acc_q : acc_q;
        quot_fix  = quot_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // NOTE: datapath registers are reset along with control so no X ever reaches hi/lo.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dvsr_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                dbz_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        quot_neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        rem_neg_q  <= is_signed & a_q[WIDTH-1];
                        cnt_q      <= CNT_W'(WIDTH);
                        acc_q      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        dvsr_q     <= is_div ? b_mag : a_mag;
                        state_q    <= dz ? S_FIX : S_ITER;
                    end
                    S_ITER: begin
                        if (is_div) begin
                            acc_q <= div_acc;
                            cnt_q <= cnt_q - 1'b1;
                            if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                        end else if (EARLY_TERM && mult_rest_zero) begin
                            // Product already sits cnt_q bits too high; align in one shift.
                            acc_q   <= acc_q >> cnt_q;
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end else begin
                            acc_q <= mult_acc;
                            cnt_q <= cnt_q - 1'b1;
                            if (!EARLY_TERM && cnt_q == CNT_W'(1)) state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (dz) begin
                            hi_q  <= a_q;
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign iter_count  = cnt_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit with its own HI/LO result registers. It is the parametrised successor of the core's fixed 32-bit shift-add multiplier, adding width, signed/unsigned modes, restoring division, abort and divide-by-zero reporting. It sits beside the ALU. Control starts it with a start/op pulse, waits on busy/done, then reads hi/lo through the ALUOut source mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width in bits; products are 2*WIDTH bits; legal range 8..64.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not to be overridden).

Ports:
Clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
abort  input  1  cancels the operation in progress
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse; hi/lo are valid from this cycle
div_by_zero  output  1  high with done when a DIV/DIVU had b==0; holds until the next start
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
iter_count  output  CNT_W  iterations remaining; debug only

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; hi, lo, iter_count = 0; busy, done, div_by_zero = 0. Reset mid-operation discards the operation with no done pulse.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD -> ITER, or LOAD -> FIX when the op is a divide with b==0.
  - ITER -> FIX after WIDTH iterations.
  - FIX -> IDLE.
- LOAD (1 cycle):
  - Latch the op.
  - Signed ops: store |a| and |b| and record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
  - Unsigned ops: store operands unchanged, with sign_q = sign_r = 0.
  - iter_count = WIDTH.
- ITER, multiply: one shift-add step per cycle on a 2*WIDTH accumulator; iter_count decrements by 1 per cycle.
- ITER, divide: one restoring step per cycle: shift the remainder:quotient pair left, trial-subtract the divisor, set the quotient bit if the result is non-negative, restore otherwise.
- FIX (1 cycle): write hi/lo; done=1 in the cycle after this edge.
  - Multiply: product is negated as 2*WIDTH bits if sign_q; hi = upper half, lo = lower half.
  - Divide: quotient negated if sign_q, remainder negated if sign_r; lo = quotient, hi = remainder.
- Latency: start sampled at edge k -> done high during the cycle following edge k+WIDTH+2 (WIDTH+2 cycles busy). busy deasserts in the same cycle that done is high.
- Divide by zero: LOAD goes straight to FIX. FIX writes hi = a and lo = all-ones and sets div_by_zero=1; done follows 2 cycles after start.
- Signed overflow: DIV of -2^(W-1) by -1 gives lo = -2^(W-1) (wraps) and hi = 0. No flag is raised.
- start while busy is ignored; operands are not re-sampled.
- start in the same cycle as done (state back in IDLE) is accepted.
- abort=1 in any state other than IDLE -> IDLE at the next edge. No done; hi/lo keep their previous values; div_by_zero cleared.
- abort has priority over completion in FIX.
- hi/lo are written only in FIX and are stable otherwise.

Optional Feature:
Macro MULTDIV_EARLY_TERM_EN.
- Defined: an unsigned-magnitude multiply goes ITER -> FIX as soon as the remaining multiplier bits are all zero. The accumulator is aligned by shifting in one step. Latency becomes 3 + (index of the highest set bit of |b| + 1) cycles; b==0 gives 3 cycles. Divide timing is unchanged.
- Not defined: fixed WIDTH+2 latency for every multiply.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 34 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> done 2 cycles after start, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT running; at cycle 10 drive start with new operands -> ignored. At cycle 15 abort=1 -> IDLE next edge, no done, hi/lo hold the prior result. Back-to-back start in the done cycle is accepted.
- reset pulsed low mid-DIV -> outputs 0 immediately (asynchronously). WIDTH=16 build repeats MULT -3*7 -> hi=0xFFFF, lo=0xFFEB at cycle 18. With MULTDIV_EARLY_TERM_EN, MULTU 5*3 -> done at cycle 5.
